frac_clk_gen: RTL and testbench
===============================

FRAC_CLK_GEN -- requirements
Module: frac_clk_gen

Interface
REQ-001 SHALL provide parameter CHANNELS, default 2, the number of independent clock-enable channels (1..8).
REQ-002 SHALL provide parameter ACC_WIDTH, default 16, the width of the M/D numerator, denominator and accumulator.
REQ-003 SHALL provide parameter LOCK_PULSES, default 4, the number of ce pulses after a config takes effect before locked asserts (1..255).
REQ-004 SHALL define local CH_W = max(1, clog2(CHANNELS)).
REQ-005 Port: clk  in  1  single system clock; all logic is in this domain.
REQ-006 Port: reset  in  1  asynchronous, active-low reset.
REQ-007 Port: cfg_valid  in  1  config request.
REQ-008 Port: cfg_ready  out  1  config accept; a transfer occurs when cfg_valid and cfg_ready are both high in the same cycle.
REQ-009 Port: cfg_ch  in  CH_W  target channel.
REQ-010 Port: cfg_mul  in  ACC_WIDTH  multiply value M; 0 disables the channel.
REQ-011 Port: cfg_div  in  ACC_WIDTH  divide value D.
REQ-012 Port: cfg_err  out  1  one-cycle pulse when an accepted config is rejected.
REQ-013 Port: ce  out  CHANNELS  per-channel one-cycle clock-enable pulses at an average rate of clk*M/D.
REQ-014 Port: clk_out  out  CHANNELS  per-channel square wave that toggles on every ce pulse.
REQ-015 Port: locked  out  CHANNELS  per-channel indicator that the configuration has settled.

Function
REQ-016 Each channel SHALL hold active registers mul, div and acc, plus one pending config slot.
- Each cycle an enabled channel (mul != 0) computes sum = acc + mul at ACC_WIDTH+1 bits.
- If sum >= div: acc <= sum - div and ce is registered high for the following cycle.
- Otherwise: acc <= sum.
REQ-017 A disabled channel SHALL hold acc at 0, ce at 0 and locked at 0, and SHALL hold clk_out at its current level.
REQ-018 A config SHALL be rejected, with cfg_err pulsing high in the cycle after acceptance and no state change, if any of the following holds:
- cfg_div == 0 while cfg_mul != 0;
- cfg_mul > cfg_div;
- cfg_ch >= CHANNELS.
REQ-019 A valid config for a disabled channel SHALL take effect in the cycle after acceptance.
- Takes effect means: mul and div are loaded, acc is cleared to 0, and locked is cleared.
REQ-020 A valid config for an enabled channel SHALL be held pending and applied in the first cycle in which that channel's ce is high (pulse-boundary switch).
- At application, acc is cleared and locked is cleared.
- clk_out phase is preserved; no runt pulse is produced.
REQ-021 Applying a config with mul == 0 SHALL disable the channel at the application point defined in REQ-019/REQ-020.
REQ-022 cfg_ready SHALL be low whenever any channel has a pending config, and high otherwise.
- No new request is accepted while an update is pending.
REQ-023 locked[ch] SHALL assert coincident with the LOCK_PULSES-th ce pulse after a config takes effect, and SHALL remain high until the next application or disable.
REQ-024 With M == D, ce[ch] SHALL be high every cycle, from the second cycle after the config takes effect.
REQ-025 Over any window of D*k cycles in steady state, a channel SHALL emit exactly M*k ce pulses (no drift, no accumulator overflow).
REQ-026 Channels SHALL operate independently; a config for one channel SHALL NOT perturb the acc, ce or locked of any other channel.

Reset
REQ-027 While reset is low, and immediately on its assertion (asynchronously, including mid-operation or while a config is pending), all outputs SHALL take these values:
- ce = 0, clk_out = 0, locked = 0, cfg_err = 0, cfg_ready = 1;
- every channel mul = 0 (disabled), div = 0, acc = 0;
- all pending slots empty.
REQ-028 After reset deassertion, the first config SHALL be acceptable in the first rising edge of clk.

Verification
REQ-029 Accept ch0 M=1 D=4 at cycle A -> ce[0] high at A+5, A+9, A+13, ...; clk_out[0] toggles at each pulse; locked[0] rises at A+17 (4th pulse).
REQ-030 Enabled ch0 M=25 D=50, then send M=1 D=3 -> cfg_ready low until ch0's next ce pulse; new rate applies from that pulse; clk_out has no glitch; ch1 is unaffected.
REQ-031 Send M=5 D=3, D=0 with M=2, and cfg_ch=CHANNELS in turn -> cfg_err pulses once per request; ce, locked and active config are unchanged.
REQ-032 Run M=7 D=16 for 1600 cycles -> exactly 700 ce pulses; M=D=9 -> ce continuously high.
REQ-033 Assert reset mid-operation with a config pending -> all outputs go to reset values immediately; pending config is discarded; cfg_ready = 1.

Source files
------------

// File: rtl/frac_clk_gen.sv
// Fractional clock-enable generator.
// Each channel runs a modulo-D phase accumulator stepped by M and emits one-cycle
// ce pulses at an average rate of clk*M/D, plus a square wave toggling per pulse.
// Reconfiguring a running channel is deferred to its next ce pulse so the output
// square wave never produces a runt half-period.
module frac_clk_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_WIDTH   = 16,
    parameter int LOCK_PULSES = 4,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [ACC_WIDTH-1:0] cfg_mul,
    input  logic [ACC_WIDTH-1:0] cfg_div,
    output logic                 cfg_err,
    output logic [CHANNELS-1:0]  ce,
    output logic [CHANNELS-1:0]  clk_out,
    output logic [CHANNELS-1:0]  locked
);

    localparam logic [31:0] CH_LIMIT = CHANNELS;
    localparam logic [7:0]  LOCK_CNT = 8'(LOCK_PULSES);

    logic [CHANNELS-1:0] pend_vec;
    logic                cfg_fire;
    logic                cfg_bad;
    logic                cfg_good;
    logic                cfg_err_q;
    logic                cfg_err_d;

    // A single pending slot anywhere blocks new requests.
    assign cfg_ready = ~(|pend_vec);
    assign cfg_err   = cfg_err_q;

    // Handshake and validity screening of the incoming request.
    always_comb begin
        cfg_fire  = cfg_valid && cfg_ready;
        cfg_bad   = ((cfg_mul != '0) && (cfg_div == '0))
                 || (cfg_mul > cfg_div)
                 || (32'(cfg_ch) >= CH_LIMIT);
        cfg_good  = cfg_fire && !cfg_bad;
        cfg_err_d = cfg_fire && cfg_bad;
    end

    // Error pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [ACC_WIDTH-1:0] mul_q, mul_d;
            logic [ACC_WIDTH-1:0] div_q, div_d;
            logic [ACC_WIDTH-1:0] acc_q, acc_d;
            logic [ACC_WIDTH-1:0] pmul_q, pmul_d;
            logic [ACC_WIDTH-1:0] pdiv_q, pdiv_d;
            logic [7:0]           cnt_q, cnt_d;
            logic                 ce_q, ce_d;
            logic                 clk_q, clk_d;
            logic                 locked_q, locked_d;
            logic                 pend_q, pend_d;
            logic [ACC_WIDTH:0]   sum;
            logic                 sel;

            assign ce[gi]       = ce_q;
            assign clk_out[gi]  = clk_q;
            assign locked[gi]   = locked_q;
            assign pend_vec[gi] = pend_q;

            // Accumulator step, pulse-boundary config switch and lock counting.
            always_comb begin
                mul_d    = mul_q;
                div_d    = div_q;
                acc_d    = acc_q;
                pmul_d   = pmul_q;
                pdiv_d   = pdiv_q;
                cnt_d    = cnt_q;
                ce_d     = 1'b0;
                clk_d    = clk_q;
                locked_d = locked_q;
                pend_d   = pend_q;
                sum      = {1'b0, acc_q} + {1'b0, mul_q};
                sel      = cfg_good && (cfg_ch == CH_W'(gi));

                if (mul_q == '0) begin
                    // Idle channel: config lands immediately, square wave holds level.
                    acc_d    = '0;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                    if (sel) begin
                        mul_d = cfg_mul;
                        div_d = cfg_div;
                    end
                end else if (pend_q && ce_q) begin
                    // Switch at the pulse boundary; restart the phase from zero.
                    mul_d    = pmul_q;
                    div_d    = pdiv_q;
                    acc_d    = '0;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                    pend_d   = 1'b0;
                end else begin
                    if (sum >= {1'b0, div_q}) begin
                        acc_d = ACC_WIDTH'(sum - {1'b0, div_q});
                        ce_d  = 1'b1;
                        clk_d = ~clk_q;
                        if (!locked_q) begin
                            cnt_d = cnt_q + 8'd1;
                            if (cnt_q + 8'd1 == LOCK_CNT) begin
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        acc_d = sum[ACC_WIDTH-1:0];
                    end
                    if (sel) begin
                        pend_d = 1'b1;
                        pmul_d = cfg_mul;
                        pdiv_d = cfg_div;
                    end
                end
            end

            // Channel state registers.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    mul_q    <= '0;
                    div_q    <= '0;
                    acc_q    <= '0;
                    pmul_q   <= '0;
                    pdiv_q   <= '0;
                    cnt_q    <= '0;
                    ce_q     <= 1'b0;
                    clk_q    <= 1'b0;
                    locked_q <= 1'b0;
                    pend_q   <= 1'b0;
                end else begin
                    mul_q    <= mul_d;
                    div_q    <= div_d;
                    acc_q    <= acc_d;
                    pmul_q   <= pmul_d;
                    pdiv_q   <= pdiv_d;
                    cnt_q    <= cnt_d;
                    ce_q     <= ce_d;
                    clk_q    <= clk_d;
                    locked_q <= locked_d;
                    pend_q   <= pend_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_frac_clk_gen.sv
// Self-checking bench for frac_clk_gen: directed scenarios plus random configs,
// compared each cycle against an arithmetic model of pulse counts.
module tb_frac_clk_gen;

    localparam int NCH  = 3;
    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_mul = '0;
    logic [15:0] cfg_div = '0;
    logic        cfg_ready;
    logic        cfg_err;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] locked;

    frac_clk_gen #(
        .CHANNELS   (NCH),
        .ACC_WIDTH  (16),
        .LOCK_PULSES(LOCK)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_mul  (cfg_mul),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .ce       (ce),
        .clk_out  (clk_out),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    // Reference model: a running channel with rate M/D that took effect in cycle T
    // has emitted floor((c-T)*M/D) pulses by cycle c.
    bit     en    [NCH];
    longint t_eff [NCH];
    longint mm    [NCH];
    longint dd    [NCH];
    bit     lvl   [NCH];
    bit     pend  [NCH];
    longint pm    [NCH];
    longint pd    [NCH];
    bit     exp_err;
    bit     fired;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            en[i] = 1'b0; t_eff[i] = 0; mm[i] = 0; dd[i] = 1;
            lvl[i] = 1'b0; pend[i] = 1'b0; pm[i] = 0; pd[i] = 0;
        end
        exp_err = 1'b0;
    endfunction

    function automatic longint cnt_e(int ch, longint c);
        if (c <= t_eff[ch]) return 0;
        return ((c - t_eff[ch]) * mm[ch]) / dd[ch];
    endfunction

    function automatic bit ce_e(int ch, longint c);
        if (!en[ch] || c <= t_eff[ch]) return 1'b0;
        return cnt_e(ch, c) != cnt_e(ch, c - 1);
    endfunction

    function automatic bit clk_e(int ch, longint c);
        longint n;
        if (!en[ch]) return lvl[ch];
        n = cnt_e(ch, c);
        return lvl[ch] ^ n[0];
    endfunction

    function automatic bit lk_e(int ch, longint c);
        if (!en[ch]) return 1'b0;
        return cnt_e(ch, c) >= LOCK;
    endfunction

    function automatic bit any_pend();
        bit r = 1'b0;
        for (int i = 0; i < NCH; i++) r |= pend[i];
        return r;
    endfunction

    task automatic check_outputs();
        logic [NCH-1:0] e_ce, e_clk, e_lk;
        logic e_rdy;
        for (int i = 0; i < NCH; i++) begin
            e_ce[i]  = ce_e(i, cyc);
            e_clk[i] = clk_e(i, cyc);
            e_lk[i]  = lk_e(i, cyc);
        end
        e_rdy = !any_pend();
        checks++;
        assert (ce === e_ce) else begin
            errors++; $error("FAIL ce cyc=%0d got=%b exp=%b", cyc, ce, e_ce);
        end
        checks++;
        assert (clk_out === e_clk) else begin
            errors++; $error("FAIL clk_out cyc=%0d got=%b exp=%b", cyc, clk_out, e_clk);
        end
        checks++;
        assert (locked === e_lk) else begin
            errors++; $error("FAIL locked cyc=%0d got=%b exp=%b", cyc, locked, e_lk);
        end
        checks++;
        assert (cfg_ready === e_rdy) else begin
            errors++; $error("FAIL cfg_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, e_rdy);
        end
        checks++;
        assert (cfg_err === exp_err) else begin
            errors++; $error("FAIL cfg_err cyc=%0d got=%b exp=%b", cyc, cfg_err, exp_err);
        end
    endtask

    // One clock: advance the model across the edge, then compare all outputs.
    task automatic step();
        bit     rdy, bad;
        int     ch;
        longint m, d;
        @(posedge clk);
        cyc++;
        exp_err = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            rdy = !any_pend();
            for (int i = 0; i < NCH; i++) begin
                if (pend[i] && ce_e(i, cyc - 1)) begin
                    lvl[i]  = clk_e(i, cyc - 1);
                    pend[i] = 1'b0;
                    if (pm[i] == 0) begin
                        en[i] = 1'b0;
                    end else begin
                        mm[i] = pm[i]; dd[i] = pd[i]; t_eff[i] = cyc;
                    end
                end
            end
            if (cfg_valid && rdy) begin
                fired = 1'b1;
                ch  = int'(cfg_ch);
                m   = longint'(cfg_mul);
                d   = longint'(cfg_div);
                bad = (m != 0 && d == 0) || (m > d) || (ch >= NCH);
                if (bad) begin
                    exp_err = 1'b1;
                end else if (!en[ch]) begin
                    if (m != 0) begin
                        en[ch] = 1'b1; mm[ch] = m; dd[ch] = d; t_eff[ch] = cyc;
                    end
                end else begin
                    pend[ch] = 1'b1; pm[ch] = m; pd[ch] = d;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic send(input int ch, input int m, input int d);
        int waited = 0;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_mul   = 16'(m);
        cfg_div   = 16'(d);
        fired     = 1'b0;
        while (!fired && waited < 500) begin
            step();
            waited++;
        end
        cfg_valid = 1'b0;
        $display("cfg ch=%0d M=%0d D=%0d accepted at cyc=%0d err=%b", ch, m, d, cyc, cfg_err);
        checks++;
        assert (fired) else begin
            errors++; $error("FAIL send_timeout got=%b exp=%b", fired, 1'b1);
        end
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (any_pend() && waited < 300) begin
            step();
            waited++;
        end
        checks++;
        assert (cfg_ready === 1'b1) else begin
            errors++; $error("FAIL idle_timeout got=%b exp=%b", cfg_ready, 1'b1);
        end
    endtask

    initial begin
        longint t0, lock_cyc;
        int     pulses, ch, m, d, idle;

        model_reset();
        repeat (3) step();
        rst_n = 1'b1;

        // Basic 1/4 rate: pulses every 4 cycles, lock on the 4th pulse.
        send(0, 1, 4);
        t0 = cyc;
        lock_cyc = -1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (lock_cyc < 0 && locked[0] === 1'b1) lock_cyc = cyc;
        end
        checks++;
        assert (lock_cyc == t0 + 16) else begin
            errors++; $error("FAIL lock_time got=%0d exp=%0d", lock_cyc, t0 + 16);
        end

        // Pulse-boundary switching with other channels running.
        send(1, 25, 50);
        send(0, 25, 50);
        send(2, 3, 7);
        repeat (60) step();
        send(0, 1, 3);
        repeat (60) step();

        // Rejected requests: one error pulse each, nothing else disturbed.
        send(0, 5, 3);
        checks++;
        assert (cfg_err === 1'b1) else begin
            errors++; $error("FAIL err_m_gt_d got=%b exp=%b", cfg_err, 1'b1);
        end
        step();
        checks++;
        assert (cfg_err === 1'b0) else begin
            errors++; $error("FAIL err_width got=%b exp=%b", cfg_err, 1'b0);
        end
        send(1, 2, 0);
        checks++;
        assert (cfg_err === 1'b1) else begin
            errors++; $error("FAIL err_d_zero got=%b exp=%b", cfg_err, 1'b1);
        end
        step();
        send(NCH, 1, 2);
        checks++;
        assert (cfg_err === 1'b1) else begin
            errors++; $error("FAIL err_bad_ch got=%b exp=%b", cfg_err, 1'b1);
        end
        repeat (10) step();

        // Random configs, including disables, M==D and illegal requests.
        for (int n = 0; n < 40; n++) begin
            ch = ($urandom_range(0, 9) == 0) ? NCH : int'($urandom_range(0, NCH - 1));
            d  = int'($urandom_range(1, 20));
            case ($urandom_range(0, 9))
                0:       m = 0;
                1:       m = d + 1;
                2:       begin m = int'($urandom_range(1, 5)); d = 0; end
                3:       m = d;
                default: m = int'($urandom_range(1, d));
            endcase
            send(ch, m, d);
            idle = int'($urandom_range(0, 25));
            repeat (idle) step();
        end

        // Long-run exactness: 7/16 over 1600 cycles, then M==D continuous.
        send(0, 7, 16);
        wait_idle();
        repeat (20) step();
        pulses = 0;
        repeat (1600) begin
            step();
            pulses += int'(ce[0]);
        end
        checks++;
        assert (pulses == 700) else begin
            errors++; $error("FAIL pulse_count got=%0d exp=%0d", pulses, 700);
        end
        send(0, 9, 9);
        wait_idle();
        repeat (5) step();
        pulses = 0;
        repeat (40) begin
            step();
            pulses += int'(ce[0]);
        end
        checks++;
        assert (pulses == 40) else begin
            errors++; $error("FAIL ce_continuous got=%0d exp=%0d", pulses, 40);
        end

        // Asynchronous reset with a config pending.
        send(2, 3, 7);
        wait_idle();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_mul = 16'd5; cfg_div = 16'd9;
        fired = 1'b0;
        step();
        cfg_valid = 1'b0;
        checks++;
        assert (cfg_ready === 1'b0) else begin
            errors++; $error("FAIL pending_ready got=%b exp=%b", cfg_ready, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted at cyc=%0d", cyc);
        checks++;
        assert (ce === '0) else begin
            errors++; $error("FAIL rst_ce got=%b exp=%b", ce, 3'b000);
        end
        checks++;
        assert (clk_out === '0) else begin
            errors++; $error("FAIL rst_clk_out got=%b exp=%b", clk_out, 3'b000);
        end
        checks++;
        assert (locked === '0) else begin
            errors++; $error("FAIL rst_locked got=%b exp=%b", locked, 3'b000);
        end
        checks++;
        assert (cfg_err === 1'b0) else begin
            errors++; $error("FAIL rst_cfg_err got=%b exp=%b", cfg_err, 1'b0);
        end
        checks++;
        assert (cfg_ready === 1'b1) else begin
            errors++; $error("FAIL rst_cfg_ready got=%b exp=%b", cfg_ready, 1'b1);
        end
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        send(1, 1, 2);
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
